// File: rtl/mem_if_pkg.sv
// Line-interface widths and responder state encoding shared by mem_ctrl, the caches and the responder.
package mem_if_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    COOL
  } state_t;
endpackage

// File: rtl/line_ram.sv
// Single-port line storage: synchronous write, combinational read of the presented index.
module line_ram
  import mem_if_pkg::*;
#(
  parameter int    LINE_W    = mem_if_pkg::LINE_W,
  parameter int    IDX_W     = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/line_mem_responder.sv
// DRAM model below mem_ctrl: one line read/write at a time, response pulse LATENCY cycles after acceptance,
// then one cool-down cycle; req is not sampled while busy, so a held req is re-accepted every LATENCY+2 cycles.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int    LINE_W    = mem_if_pkg::LINE_W,
  parameter int    ADDR_W    = mem_if_pkg::ADDR_W,
  parameter int    IDX_W     = 12,
  parameter int    LATENCY   = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              read_rdy,
  output logic              write_ack,
  output logic              busy
);
  localparam int               CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] ram_rdata;
  logic              finishing;
  logic              ram_we;
  logic              unused_addr_hi;

  // Upper address bits alias onto the same line.
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];

  assign finishing = (state == WAIT) && (counter == LAST);
  // A reset on the response edge must also suppress the commit.
  assign ram_we    = finishing && wr_q && !reset;

  line_ram #(
    .LINE_W    (LINE_W),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      read_rdy  <= 1'b0;
      write_ack <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rdata     <= '0;
      read_rdy  <= 1'b0;
      write_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q    <= is_write;
            idx_q   <= addr[IDX_W-1:0];
            wdata_q <= wdata;
            counter <= CNT_W'(1);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          counter <= counter + CNT_W'(1);
          if (finishing) begin
            state <= RESP;
            if (wr_q) begin
              write_ack <= 1'b1;
            end else begin
              read_rdy <= 1'b1;
              rdata    <= ram_rdata;
            end
          end
        end
        RESP: state <= COOL;
        COOL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed-plus-random bench for line_mem_responder against a per-line array model of storage.
module tb_line_mem_responder;
  import mem_if_pkg::*;

  localparam int L = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic         is_write;
  logic [25:0]  addr;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic         read_rdy;
  logic         write_ack;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [127:0] model [int];
  logic [25:0]  pool [$];

  always #5 clk = ~clk;

  line_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .is_write  (is_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .read_rdy  (read_rdy),
    .write_ack (write_ack),
    .busy      (busy)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int line_of(input logic [25:0] a);
    return int'(a % 26'd4096);
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive a request in the current (idle) cycle and follow it through cool-down into the next idle cycle.
  task automatic do_txn(input bit we, input logic [25:0] a, input logic [127:0] d, input bit hold);
    logic [127:0] exp;
    bit           resp;
    exp      = we ? 128'h0 : model[line_of(a)];
    req      = 1'b1;
    is_write = we;
    addr     = a;
    wdata    = d;
    for (int c = 1; c <= L + 2; c++) begin
      step;
      resp = (c == L);
      check_bit($sformatf("busy c%0d", c), busy, c <= L + 1);
      check_bit($sformatf("read_rdy c%0d", c), read_rdy, resp && !we);
      check_bit($sformatf("write_ack c%0d", c), write_ack, resp && we);
      check_line($sformatf("rdata c%0d a=%h", c, a), rdata, (resp && !we) ? exp : 128'h0);
      if (c <= L) begin
        is_write = 1'($urandom);
        addr     = 26'($urandom);
        wdata    = rand_line();
      end
      if (c == L + 1 && !hold) req = 1'b0;
    end
    if (we) model[line_of(a)] = d;
  endtask

  // Accept a request, then assert reset during cycle rc; nothing may complete afterwards.
  task automatic abort_txn(input bit we, input logic [25:0] a, input logic [127:0] d, input int rc);
    req      = 1'b1;
    is_write = we;
    addr     = a;
    wdata    = d;
    for (int c = 1; c <= rc; c++) begin
      step;
      check_bit($sformatf("abort busy c%0d", c), busy, 1'b1);
      check_bit($sformatf("abort pulse c%0d", c), read_rdy | write_ack, 1'b0);
    end
    reset = 1'b1;
    req   = 1'b0;
    step;
    reset = 1'b0;
    for (int c = 0; c <= L + 2; c++) begin
      check_bit($sformatf("post-abort busy c%0d", c), busy, 1'b0);
      check_bit($sformatf("post-abort read_rdy c%0d", c), read_rdy, 1'b0);
      check_bit($sformatf("post-abort write_ack c%0d", c), write_ack, 1'b0);
      check_line($sformatf("post-abort rdata c%0d", c), rdata, 128'h0);
      step;
    end
  endtask

  initial begin
    logic [127:0] line_a;
    logic [25:0]  a;
    bit           we;

    // Reset held three cycles with a request pending.
    reset    = 1'b1;
    req      = 1'b1;
    is_write = 1'b1;
    addr     = 26'h5;
    wdata    = rand_line();
    for (int i = 0; i < 3; i++) begin
      step;
      check_bit("reset busy", busy, 1'b0);
      check_bit("reset read_rdy", read_rdy, 1'b0);
      check_bit("reset write_ack", write_ack, 1'b0);
      check_line("reset rdata", rdata, 128'h0);
      check_bit("reset state idle", dut.state == IDLE, 1'b1);
    end
    reset = 1'b0;
    req   = 1'b0;
    step;
    check_bit("no accept during reset", busy, 1'b0);

    // Directed write then read-back.
    do_txn(1'b1, 26'h0000005, 128'hDEADBEEF_00000001_CAFEF00D_12345678, 1'b0);
    pool.push_back(26'h0000005);
    do_txn(1'b0, 26'h0000005, 128'h0, 1'b0);

    // Aliasing through the unused upper address bits.
    line_a = rand_line();
    do_txn(1'b1, 26'h0001005, line_a, 1'b0);
    do_txn(1'b0, 26'h0000005, 128'h0, 1'b0);
    do_txn(1'b0, 26'h3FFF005, 128'h0, 1'b0);

    // Reset mid-read, then a normal read.
    abort_txn(1'b0, 26'h0000005, 128'h0, 5);
    do_txn(1'b0, 26'h0000005, 128'h0, 1'b0);
    // Reset mid-write and on the response edge: the old line must survive.
    abort_txn(1'b1, 26'h0000005, rand_line(), 7);
    do_txn(1'b0, 26'h0000005, 128'h0, 1'b0);
    abort_txn(1'b1, 26'h0000005, rand_line(), L - 1);
    do_txn(1'b0, 26'h0000005, 128'h0, 1'b0);

    // Continuous req: each transaction accepted every L+2 cycles with its own address.
    for (int i = 0; i < 12; i++) begin
      we = (i % 3 == 0) || (i == 1 ? 1'b0 : 1'($urandom));
      if (we) begin
        a = 26'($urandom);
        pool.push_back(a);
      end else begin
        a = pool[$urandom_range(0, pool.size() - 1)];
        a = {14'($urandom), a[11:0]};
      end
      do_txn(we, a, rand_line(), i != 11);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
